// File: rtl/vrased_pkg.sv
// Shared types and constants for the VRASED violation-to-reset controller.
package vrased_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        HOLD         = 2'b01,
        WAIT_HANDLER = 2'b10
    } state_t;

    localparam logic [15:0] RESET_HANDLER = 16'hfffe;

    localparam int SRC_ATOMICITY = 0;
    localparam int SRC_KEY       = 1;
    localparam int SRC_DMA       = 2;
    localparam int SRC_STACK     = 3;

endpackage

// File: rtl/vrased_reset_ctrl_if.sv
// Monitor-side bundle of the reset controller; level signals only, no handshake.
interface vrased_reset_ctrl_if
    import vrased_pkg::*;
#(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] viol_in;
    logic [15:0]      pc;
    logic             clr_cause;
    logic             vrased_reset;
    logic [N_SRC-1:0] cause;
    logic [7:0]       viol_count;
    logic             busy;
    state_t           state;

    modport master (
        output viol_in, pc, clr_cause,
        input  vrased_reset, cause, viol_count, busy, state
    );

    modport slave (
        input  viol_in, pc, clr_cause,
        output vrased_reset, cause, viol_count, busy, state
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/vrased_reset_ctrl.sv
// Turns any monitor violation into one fixed-width PUC reset pulse, then waits
// for the CPU to reach the reset handler before accepting the next event.
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter int          N_SRC         = 4,
    parameter int          HOLD_CYCLES   = 8,
    parameter logic [15:0] RESET_HANDLER = vrased_pkg::RESET_HANDLER
) (
    input logic                clk,
    input logic                reset,
    vrased_reset_ctrl_if.slave bus
);
    state_t           state;
    logic [7:0]       hold_cnt;
    logic [N_SRC-1:0] cause;
    logic             pulse;
    logic             busy;
    logic             accept;

    // Only a violation seen from IDLE counts as a new event.
    assign accept = (state == IDLE) && (|bus.viol_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            cause    <= '0;
            pulse    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.viol_in) begin
                        cause    <= bus.viol_in;
                        hold_cnt <= 8'(HOLD_CYCLES - 1);
                        pulse    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HOLD;
                    end else if (bus.clr_cause) begin
                        cause <= '0;
                    end
                end
                HOLD: begin
                    cause <= cause | bus.viol_in;
                    if (hold_cnt == 8'd0) begin
                        pulse <= 1'b0;
                        state <= WAIT_HANDLER;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                WAIT_HANDLER: begin
                    // Monitors stay asserted until the handler runs, so no retrigger here.
                    cause <= cause | bus.viol_in;
                    if (bus.pc == RESET_HANDLER) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(8)) u_viol_count (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (bus.viol_count)
    );

    assign bus.vrased_reset = pulse;
    assign bus.cause        = cause;
    assign bus.busy         = busy;
    assign bus.state        = state;
endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Bench for vrased_reset_ctrl: two instances (8-cycle and 1-cycle pulse) share stimulus.
module tb_vrased_reset_ctrl;
    import vrased_pkg::*;

    localparam int HOLD0 = 8;
    localparam int HOLD1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  viol_in = 4'b0;
    logic [15:0] pc = 16'h0;
    logic        clr_cause = 1'b0;

    int total = 0;
    int bad = 0;
    int exp_count = 0;
    logic [3:0] exp_cause = 4'b0;

    vrased_reset_ctrl_if #(.N_SRC(4)) bus0 ();
    vrased_reset_ctrl_if #(.N_SRC(4)) bus1 ();

    assign bus0.viol_in   = viol_in;
    assign bus0.pc        = pc;
    assign bus0.clr_cause = clr_cause;
    assign bus1.viol_in   = viol_in;
    assign bus1.pc        = pc;
    assign bus1.clr_cause = clr_cause;

    vrased_reset_ctrl #(.N_SRC(4), .HOLD_CYCLES(HOLD0), .RESET_HANDLER(16'hfffe)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    vrased_reset_ctrl #(.N_SRC(4), .HOLD_CYCLES(HOLD1), .RESET_HANDLER(16'hfffe)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    // One complete event: violation at edge k, hold_v during edges k+1..k+8,
    // wait_v afterwards, handler PC at edge k+8+wait_len. Reports what was seen
    // after each edge k..k+8+wait_len.
    task automatic do_event(input logic [3:0] v0, input logic [3:0] hold_v,
                            input logic [3:0] wait_v, input logic clr0,
                            input logic clr_busy, input logic pc_early,
                            input int wait_len,
                            output int hi0, output int first0, output int rises0,
                            output int busy0, output int hi1, output int busy1);
        logic prev;
        int last;
        hi0 = 0; first0 = -1; rises0 = 0; busy0 = 0; hi1 = 0; busy1 = 0;
        prev = bus0.vrased_reset;
        last = HOLD0 + wait_len;
        for (int j = 0; j <= last; j++) begin
            viol_in   = (j == 0) ? v0 : ((j <= HOLD0) ? hold_v : wait_v);
            clr_cause = (j == 0) ? clr0 : clr_busy;
            pc        = ((j == last) || (pc_early && j == 1)) ? 16'hfffe : 16'h0000;
            tick();
            if (bus0.vrased_reset) begin
                hi0++;
                if (first0 < 0) first0 = j;
                if (!prev) rises0++;
            end
            prev = bus0.vrased_reset;
            if (bus0.busy) busy0++;
            if (bus1.vrased_reset) hi1++;
            if (bus1.busy) busy1++;
        end
        viol_in   = 4'b0;
        clr_cause = 1'b0;
        pc        = 16'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_count = 0;
        exp_cause = 4'b0;
        total++; if (bus0.vrased_reset !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", bus0.vrased_reset); end
        total++; if (bus0.cause !== 4'b0) begin bad++; $display("FAIL reset_cause: got %b want 0000", bus0.cause); end
        total++; if (bus0.viol_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus0.viol_count); end
        total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        total++; if (bus0.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus0.state, IDLE); end
        total++; if (bus1.viol_count !== 8'd0) begin bad++; $display("FAIL reset_count1: got %0d want 0", bus1.viol_count); end
    endtask

    task automatic test_single();
        int hi0, first0, rises0, busy0, hi1, busy1;
        do_event(4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        total++; if (first0 !== 0) begin bad++; $display("FAIL single_latency: got %0d want 0", first0); end
        total++; if (hi0 !== HOLD0) begin bad++; $display("FAIL single_width: got %0d want %0d", hi0, HOLD0); end
        total++; if (rises0 !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", rises0); end
        total++; if (busy0 !== HOLD0 + 4) begin bad++; $display("FAIL single_busy: got %0d want %0d", busy0, HOLD0 + 4); end
        total++; if (bus0.cause !== 4'b0001) begin bad++; $display("FAIL single_cause: got %b want 0001", bus0.cause); end
        total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL single_count: got %0d want %0d", bus0.viol_count, exp_count); end
        total++; if (hi1 !== HOLD1) begin bad++; $display("FAIL single_width1: got %0d want %0d", hi1, HOLD1); end
        total++; if (busy1 !== HOLD0 + 4) begin bad++; $display("FAIL single_busy1: got %0d want %0d", busy1, HOLD0 + 4); end
    endtask

    task automatic test_merge();
        int hi0, first0, rises0, busy0, hi1, busy1;
        // Handler PC during HOLD must not cut the pulse short.
        do_event(4'b0001, 4'b0100, 4'b0, 1'b0, 1'b1, 1'b1, 2, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        total++; if (bus0.cause !== 4'b0101) begin bad++; $display("FAIL merge_cause: got %b want 0101", bus0.cause); end
        total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL merge_count: got %0d want %0d", bus0.viol_count, exp_count); end
        total++; if (hi0 !== HOLD0 || rises0 !== 1) begin bad++; $display("FAIL merge_width: got %0d/%0d want %0d/1", hi0, rises0, HOLD0); end
        total++; if (busy0 !== HOLD0 + 2) begin bad++; $display("FAIL merge_busy: got %0d want %0d", busy0, HOLD0 + 2); end
        total++; if (bus1.cause !== 4'b0101) begin bad++; $display("FAIL merge_cause1: got %b want 0101", bus1.cause); end
    endtask

    task automatic test_held();
        int hi0, first0, rises0, busy0, hi1, busy1;
        int extra;
        do_event(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 5, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        extra = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (bus0.vrased_reset || bus0.busy) extra++;
        end
        total++; if (rises0 !== 1 || hi0 !== HOLD0) begin bad++; $display("FAIL held_pulse: got %0d/%0d want 1/%0d", rises0, hi0, HOLD0); end
        total++; if (extra !== 0) begin bad++; $display("FAIL held_retrigger: got %0d want 0", extra); end
        total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL held_count: got %0d want %0d", bus0.viol_count, exp_count); end
    endtask

    task automatic test_mid_reset();
        viol_in = 4'b0010;
        tick();
        viol_in = 4'b0;
        for (int j = 0; j < 3; j++) tick();
        total++; if (bus0.vrased_reset !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", bus0.vrased_reset); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        exp_cause = 4'b0;
        total++; if (bus0.vrased_reset !== 1'b0) begin bad++; $display("FAIL midrst_pulse: got %b want 0", bus0.vrased_reset); end
        total++; if (bus0.cause !== 4'b0) begin bad++; $display("FAIL midrst_cause: got %b want 0000", bus0.cause); end
        total++; if (bus0.viol_count !== 8'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", bus0.viol_count); end
        total++; if (bus0.state !== IDLE || bus0.busy !== 1'b0) begin bad++; $display("FAIL midrst_state: got %0d/%b want %0d/0", bus0.state, bus0.busy, IDLE); end
        tick();
        total++; if (bus0.vrased_reset !== 1'b0) begin bad++; $display("FAIL midrst_stay: got %b want 0", bus0.vrased_reset); end
    endtask

    task automatic test_clear();
        int hi0, first0, rises0, busy0, hi1, busy1;
        do_event(4'b0010, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        total++; if (bus0.cause !== 4'b0010) begin bad++; $display("FAIL clear_busyignore: got %b want 0010", bus0.cause); end
        clr_cause = 1'b1;
        tick();
        clr_cause = 1'b0;
        total++; if (bus0.cause !== 4'b0) begin bad++; $display("FAIL clear_idle: got %b want 0000", bus0.cause); end
        do_event(4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        total++; if (bus0.cause !== 4'b1000) begin bad++; $display("FAIL clear_vs_viol: got %b want 1000", bus0.cause); end
        total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL clear_count: got %0d want %0d", bus0.viol_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int hi0, first0, rises0, busy0, hi1, busy1;
        do_event(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        do_event(4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1, hi0, first0, rises0, busy0, hi1, busy1);
        exp_count = sat_inc(exp_count);
        total++; if (first0 !== 0 || hi0 !== HOLD0) begin bad++; $display("FAIL b2b_second: got %0d/%0d want 0/%0d", first0, hi0, HOLD0); end
        total++; if (bus0.cause !== 4'b0001) begin bad++; $display("FAIL b2b_cause: got %b want 0001", bus0.cause); end
        total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", bus0.viol_count, exp_count); end
    endtask

    task automatic test_random();
        int hi0, first0, rises0, busy0, hi1, busy1;
        logic [3:0] v0, hv, wv;
        logic c0, cb, pe;
        int wl, gap;
        exp_cause = bus0.cause;
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                clr_cause = 1'($urandom_range(0, 1));
                viol_in = 4'b0;
                tick();
                if (clr_cause) exp_cause = 4'b0;
            end
            clr_cause = 1'b0;
            total++; if (bus0.cause !== exp_cause) begin bad++; $display("FAIL rand_idle_cause[%0d]: got %b want %b", n, bus0.cause, exp_cause); end
            v0 = 4'($urandom_range(1, 15));
            hv = 4'($urandom_range(0, 15));
            wv = 4'($urandom_range(0, 15));
            c0 = 1'($urandom_range(0, 1));
            cb = 1'($urandom_range(0, 1));
            pe = 1'($urandom_range(0, 1));
            wl = $urandom_range(1, 6);
            do_event(v0, hv, wv, c0, cb, pe, wl, hi0, first0, rises0, busy0, hi1, busy1);
            exp_count = sat_inc(exp_count);
            exp_cause = v0 | hv | wv;
            total++; if (hi0 !== HOLD0 || first0 !== 0 || rises0 !== 1) begin bad++; $display("FAIL rand_pulse[%0d]: got %0d/%0d/%0d want %0d/0/1", n, hi0, first0, rises0, HOLD0); end
            total++; if (busy0 !== HOLD0 + wl || busy1 !== HOLD0 + wl) begin bad++; $display("FAIL rand_busy[%0d]: got %0d/%0d want %0d", n, busy0, busy1, HOLD0 + wl); end
            total++; if (hi1 !== HOLD1) begin bad++; $display("FAIL rand_pulse1[%0d]: got %0d want %0d", n, hi1, HOLD1); end
            total++; if (bus0.cause !== exp_cause || bus1.cause !== exp_cause) begin bad++; $display("FAIL rand_cause[%0d]: got %b/%b want %b", n, bus0.cause, bus1.cause, exp_cause); end
            total++; if (bus0.viol_count !== 8'(exp_count) || bus1.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d", n, bus0.viol_count, bus1.viol_count, exp_count); end
        end
    endtask

    task automatic test_saturate();
        int hi0, first0, rises0, busy0, hi1, busy1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        for (int n = 1; n <= 256; n++) begin
            do_event(4'b1000, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1, hi0, first0, rises0, busy0, hi1, busy1);
            exp_count = sat_inc(exp_count);
            if (n >= 254) begin
                total++; if (bus0.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", n, bus0.viol_count, exp_count); end
                total++; if (bus1.viol_count !== 8'(exp_count)) begin bad++; $display("FAIL sat_count1[%0d]: got %0d want %0d", n, bus1.viol_count, exp_count); end
            end
        end
        total++; if (hi1 !== 1 || hi0 !== HOLD0) begin bad++; $display("FAIL sat_widths: got %0d/%0d want 1/%0d", hi1, hi0, HOLD0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_merge();
        test_held();
        test_mid_reset();
        test_clear();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
